// File: rtl/iic_pkg.sv
// Shared types and constants for the I2C register sequencer.
// Byte-slot table maps (rw, idx, abort) onto one engine command.
package iic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_EVAL,
        ST_DONE
    } state_t;

    localparam logic [1:0] SP_NONE  = 2'b00;
    localparam logic [1:0] SP_STOP  = 2'b01;
    localparam logic [1:0] SP_START = 2'b10;

    localparam int TIMEOUT_DEF = 1023;

    typedef struct packed {
        logic       rw;
        logic [1:0] sp;
        logic [7:0] data;
    } byte_cmd_t;

    function automatic byte_cmd_t seq_cmd(
        input logic       rw,
        input logic [1:0] idx,
        input logic [6:0] dev,
        input logic [7:0] ra,
        input logic [7:0] wd,
        input logic       abort
    );
        byte_cmd_t c;
        c = '{rw: 1'b0, sp: SP_NONE, data: 8'h00};
        if (abort) begin
            c = '{rw: 1'b0, sp: SP_STOP, data: 8'hFF};
        end else begin
            case (idx)
                2'd0: c = '{rw: 1'b0, sp: SP_START, data: {dev, 1'b0}};
                2'd1: c = '{rw: 1'b0, sp: SP_NONE, data: ra};
                2'd2: c = rw ? '{rw: 1'b0, sp: SP_START, data: {dev, 1'b1}}
                             : '{rw: 1'b0, sp: SP_STOP, data: wd};
                default: c = '{rw: 1'b1, sp: SP_STOP, data: 8'h00};
            endcase
        end
        return c;
    endfunction

    function automatic logic [1:0] last_idx(input logic rw);
        return rw ? 2'd3 : 2'd2;
    endfunction

endpackage

// File: rtl/iic_byte_wdog.sv
// Per-byte watchdog: counts wait cycles, flags expiry at TIMEOUT.
// Saturates once expired so the flag stays stable until cleared.
module iic_byte_wdog
    import iic_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    assign expired = (cnt == W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/iic_reg_seq.sv
// I2C register read/write sequencer driving a byte-level engine.
// A failed non-final write byte is followed by a lone STOP byte.
module iic_reg_seq
    import iic_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       nack,
    output logic       tmo,
    output logic       byte_valid,
    input  logic       byte_right,
    output logic [7:0] byte_wdata,
    output logic       byte_rw,
    output logic [1:0] byte_sp,
    input  logic [7:0] byte_rdata,
    input  logic       byte_ok
);

    state_t    state;
    logic [1:0] idx;
    logic      abort;
    logic      rw_q;
    logic [6:0] dev_q;
    logic [7:0] ra_q;
    logic [7:0] wd_q;
    logic [7:0] rd_q;
    logic      ok_q;
    logic      expired;
    byte_cmd_t cmd;

    assign cmd = seq_cmd(rw_q, idx, dev_q, ra_q, wd_q, abort);

    iic_byte_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == ST_ISSUE && byte_right),
        .enable (state == ST_WAIT_LO || state == ST_WAIT_HI),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= 2'd0;
            abort      <= 1'b0;
            rw_q       <= 1'b0;
            dev_q      <= 7'd0;
            ra_q       <= 8'd0;
            wd_q       <= 8'd0;
            rd_q       <= 8'd0;
            ok_q       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= 8'd0;
            nack       <= 1'b0;
            tmo        <= 1'b0;
            byte_valid <= 1'b0;
            byte_wdata <= 8'd0;
            byte_rw    <= 1'b0;
            byte_sp    <= SP_NONE;
        end else begin
            byte_valid <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req) begin
                        rw_q  <= rw;
                        dev_q <= dev_addr;
                        ra_q  <= reg_addr;
                        wd_q  <= wdata;
                        nack  <= 1'b0;
                        tmo   <= 1'b0;
                        busy  <= 1'b1;
                        idx   <= 2'd0;
                        abort <= 1'b0;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    byte_wdata <= cmd.data;
                    byte_rw    <= cmd.rw;
                    byte_sp    <= cmd.sp;
                    if (byte_right) begin
                        byte_valid <= 1'b1;
                        state      <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (expired) begin
                        tmo   <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (!byte_right) begin
                        state <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (expired) begin
                        tmo   <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (byte_right) begin
                        rd_q  <= byte_rdata;
                        ok_q  <= byte_ok;
                        state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (abort) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (!ok_q) begin
                        nack <= 1'b1;
                        // a write byte without STOP still owes the bus a STOP
                        if (!byte_sp[0] && !byte_rw) begin
                            abort <= 1'b1;
                            state <= ST_ISSUE;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else if (idx == last_idx(rw_q)) begin
                        if (rw_q) begin
                            rdata <= rd_q;
                        end
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iic_reg_seq.sv
// Bench for iic_reg_seq: byte-engine model, command scoreboard,
// transaction table plus timeout, busy-req and reset sequences.
module tb_iic_reg_seq;

    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] dev_addr = 7'd0;
    logic [7:0] reg_addr = 8'd0;
    logic [7:0] wdata = 8'd0;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       nack;
    logic       tmo;
    logic       byte_valid;
    logic       byte_right;
    logic [7:0] byte_wdata;
    logic       byte_rw;
    logic [1:0] byte_sp;
    logic [7:0] byte_rdata;
    logic       byte_ok;

    iic_reg_seq #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rw        (rw),
        .dev_addr  (dev_addr),
        .reg_addr  (reg_addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .nack      (nack),
        .tmo       (tmo),
        .byte_valid(byte_valid),
        .byte_right(byte_right),
        .byte_wdata(byte_wdata),
        .byte_rw   (byte_rw),
        .byte_sp   (byte_sp),
        .byte_rdata(byte_rdata),
        .byte_ok   (byte_ok)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int vcount = 0;
    int vcyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // byte engine model
    int       e_num = 0;
    int       e_cnt = 0;
    bit       e_hang = 0;
    bit       e_ok = 0;
    bit [7:0] e_rd = 0;
    bit       hang_arm = 0;
    bit       unhang = 0;
    int       nack_base = 0;
    int       nack_at = 7;
    bit [7:0] e_rb = 0;

    assign byte_right = !e_hang && (e_cnt == 0);
    assign byte_ok    = e_ok;
    assign byte_rdata = e_rd;

    always @(posedge clk) begin
        if (unhang) e_hang <= 1'b0;
        if (e_cnt != 0) e_cnt <= e_cnt - 1;
        if (byte_valid && byte_right) begin
            e_cnt <= 3;
            e_num <= e_num + 1;
            e_ok  <= ((e_num - nack_base) != nack_at);
            e_rd  <= e_rb;
            if (hang_arm) e_hang <= 1'b1;
        end
    end

    typedef struct {
        bit       rw;
        bit [1:0] sp;
        bit [7:0] d;
    } bexp_t;

    bexp_t exp_q[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1 && byte_valid === 1'b1) begin
            vcount = vcount + 1;
            vcyc = cyc;
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL byte_cmd: got unexpected rw=%0b sp=%b d=%h, required none",
                         byte_rw, byte_sp, byte_wdata);
            end else begin
                bexp_t e;
                e = exp_q.pop_front();
                if (byte_rw !== e.rw || byte_sp !== e.sp || byte_right !== 1'b1 ||
                    (!e.rw && byte_wdata !== e.d)) begin
                    n_bad = n_bad + 1;
                    $display("FAIL byte_cmd: got rw=%0b sp=%b d=%h right=%0b, required rw=%0b sp=%b d=%h right=1",
                             byte_rw, byte_sp, byte_wdata, byte_right, e.rw, e.sp, e.d);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp = n_cmp + 1;
        if (got !== want) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    task automatic push_bytes(input bit r, input bit [6:0] dev, input bit [7:0] ra,
                              input bit [7:0] wd, input int nk);
        bexp_t s[4];
        int n;
        s[0] = '{1'b0, 2'b10, {dev, 1'b0}};
        s[1] = '{1'b0, 2'b00, ra};
        if (r) begin
            s[2] = '{1'b0, 2'b10, {dev, 1'b1}};
            s[3] = '{1'b1, 2'b01, 8'h00};
            n = 4;
        end else begin
            s[2] = '{1'b0, 2'b01, wd};
            s[3] = '{1'b0, 2'b00, 8'h00};
            n = 3;
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(s[i]);
            if (i == nk) begin
                if (!s[i].sp[0]) exp_q.push_back('{1'b0, 2'b01, 8'hFF});
                break;
            end
        end
    endtask

    task automatic start_txn(input bit r, input bit [6:0] dev, input bit [7:0] ra,
                             input bit [7:0] wd, input int nk, input bit [7:0] rb);
        nack_base = e_num;
        nack_at = nk;
        e_rb = rb;
        @(negedge clk);
        rw = r;
        dev_addr = dev;
        reg_addr = ra;
        wdata = wd;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        rw = ~r;
        dev_addr = ~dev;
        reg_addr = ~ra;
        wdata = ~wd;
        chk("busy_after_req", busy, 1);
    endtask

    task automatic finish_txn(input string nm, input bit en, input bit et,
                              input bit [7:0] erd, input bit poke, output int dcyc);
        bit seen;
        seen = 0;
        dcyc = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (poke && i == 3) req = 1'b1;
            if (poke && i == 4) req = 1'b0;
            if (done) seen = 1;
        end
        chk({nm, "_done_seen"}, seen, 1);
        if (seen) begin
            dcyc = cyc;
            chk({nm, "_busy_in_done"}, busy, 1);
            chk({nm, "_nack"}, nack, en);
            chk({nm, "_tmo"}, tmo, et);
            chk({nm, "_rdata"}, rdata, erd);
            if (poke) req = 1'b1;
            @(negedge clk);
            req = 1'b0;
            chk({nm, "_idle_after"}, {done, busy}, 2'b00);
            chk({nm, "_bytes_left"}, exp_q.size(), 0);
        end
        exp_q.delete();
    endtask

    typedef struct {
        bit       rw;
        bit [6:0] dev;
        bit [7:0] ra;
        bit [7:0] wd;
        int       nk;
        bit [7:0] rb;
        bit       en;
        bit [7:0] erd;
    } vec_t;

    vec_t tv[9];

    initial begin
        int dc;
        int v0;
        bit ok;
        tv[0] = '{1'b0, 7'h50, 8'h10, 8'hA5, 7, 8'h00, 1'b0, 8'h00};
        tv[1] = '{1'b1, 7'h50, 8'h20, 8'h00, 7, 8'h3C, 1'b0, 8'h3C};
        tv[2] = '{1'b0, 7'h51, 8'h33, 8'h77, 0, 8'h00, 1'b1, 8'h3C};
        tv[3] = '{1'b1, 7'h2A, 8'h81, 8'h00, 1, 8'hEE, 1'b1, 8'h3C};
        tv[4] = '{1'b0, 7'h7F, 8'hFF, 8'h00, 2, 8'h00, 1'b1, 8'h3C};
        tv[5] = '{1'b1, 7'h13, 8'h44, 8'h00, 3, 8'hC3, 1'b1, 8'h3C};
        tv[6] = '{1'b1, 7'h7F, 8'h00, 8'h00, 7, 8'h5A, 1'b0, 8'h5A};
        tv[7] = '{1'b1, 7'h50, 8'h20, 8'h00, 2, 8'h11, 1'b1, 8'h5A};
        tv[8] = '{1'b0, 7'h00, 8'h00, 8'hFF, 7, 8'h00, 1'b0, 8'h5A};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {busy, done, byte_valid, byte_wdata, byte_rw, byte_sp, rdata, nack, tmo}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            push_bytes(tv[k].rw, tv[k].dev, tv[k].ra, tv[k].wd, tv[k].nk);
            start_txn(tv[k].rw, tv[k].dev, tv[k].ra, tv[k].wd, tv[k].nk, tv[k].rb);
            finish_txn($sformatf("vec%0d", k), tv[k].en, 1'b0, tv[k].erd, 1'b0, dc);
        end

        // engine never finishes the first byte
        hang_arm = 1'b1;
        exp_q.push_back('{1'b0, 2'b10, 8'h44});
        start_txn(1'b0, 7'h22, 8'h01, 8'h02, 7, 8'h00);
        finish_txn("timeout", 1'b0, 1'b1, 8'h5A, 1'b0, dc);
        ok = (dc - vcyc >= TMO) && (dc - vcyc <= TMO + 2);
        chk("timeout_latency", ok, 1);
        hang_arm = 1'b0;
        unhang = 1'b1;
        @(negedge clk);
        unhang = 1'b0;

        // req while busy and in the done cycle must be ignored
        push_bytes(1'b0, 7'h3B, 8'h9C, 8'h5E, 7);
        start_txn(1'b0, 7'h3B, 8'h9C, 8'h5E, 7, 8'h00);
        finish_txn("busy_req", 1'b0, 1'b0, 8'h5A, 1'b1, dc);
        v0 = vcount;
        repeat (15) @(negedge clk);
        chk("busy_req_no_extra", vcount - v0, 0);
        chk("busy_req_idle", busy, 0);

        // reset in the middle of a read
        push_bytes(1'b1, 7'h50, 8'h20, 8'h00, 7);
        v0 = vcount;
        start_txn(1'b1, 7'h50, 8'h20, 8'h00, 7, 8'h99);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (vcount - v0 >= 2) ok = 1;
        end
        chk("rst_reach_byte2", ok, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs",
            {busy, done, byte_valid, byte_wdata, byte_rw, byte_sp, rdata, nack, tmo}, 0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        push_bytes(1'b0, 7'h50, 8'h10, 8'hA5, 7);
        start_txn(1'b0, 7'h50, 8'h10, 8'hA5, 7, 8'h00);
        finish_txn("post_rst_write", 1'b0, 1'b0, 8'h00, 1'b0, dc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iic_reg_seq.md
IIC_REG_SEQ -- requirements
Module: iic_reg_seq

Interface
REQ-001 Parameter TIMEOUT, default 1023, max clk cycles allowed per byte between valid issue and engine completion.
REQ-002 clk  input  1  sole clock, all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  1  one-cycle transaction request, accepted only when busy=0.
REQ-005 rw  input  1  transaction type: 0 register write, 1 register read.
REQ-006 dev_addr  input  7  7-bit slave address.
REQ-007 reg_addr  input  8  slave register address.
REQ-008 wdata  input  8  write data byte.
REQ-009 busy  output  1  transaction in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 rdata  output  8  read result, held until next successful read.
REQ-012 nack  output  1  last transaction ended on slave NACK; valid with done, held until next accept.
REQ-013 tmo  output  1  last transaction aborted on timeout; valid with done, held until next accept.
REQ-014 byte_valid  output  1  one-cycle byte command to byte engine.
REQ-015 byte_right  input  1  engine idle/result-valid (high = idle).
REQ-016 byte_wdata  output  8  byte to transmit.
REQ-017 byte_rw  output  1  0 write byte, 1 read byte.
REQ-018 byte_sp  output  2  bit1 = START before byte, bit0 = STOP after byte.
REQ-019 byte_rdata  input  8  byte received by engine.
REQ-020 byte_ok  input  1  1 = ACK received (write) / byte completed (read).

Function
REQ-021 Write sequence, bytes in order: {dev_addr,0} sp=10; reg_addr sp=00; wdata sp=01; all byte_rw=0.
REQ-022 Read sequence: {dev_addr,0} sp=10; reg_addr sp=00; {dev_addr,1} sp=10 (repeated START); read byte byte_rw=1 sp=01 (master NACK then STOP).
REQ-023 req with busy=0 latches rw, dev_addr, reg_addr, wdata and clears nack/tmo; busy=1 from next cycle; req while busy=1 is ignored.
REQ-024 States: IDLE, ISSUE, WAIT_LO, WAIT_HI, EVAL, DONE; 2-bit byte index idx, 1-bit abort flag.
REQ-025 IDLE -> ISSUE on accepted req, idx=0, abort=0.
REQ-026 ISSUE: drive byte_wdata/byte_rw/byte_sp for idx; assert byte_valid for exactly one cycle, only in a cycle with byte_right=1, then -> WAIT_LO; otherwise hold, valid=0.
REQ-027 WAIT_LO -> WAIT_HI when byte_right=0; WAIT_HI -> EVAL when byte_right=1; byte_rdata and byte_ok sampled in that cycle.
REQ-028 Timeout counter clears on ISSUE->WAIT_LO, increments each WAIT_LO/WAIT_HI cycle; reaching TIMEOUT sets tmo=1 -> DONE without STOP.
REQ-029 EVAL, write byte, byte_ok=0, byte_sp[0]=0: nack=1, abort=1, -> ISSUE with byte 0xFF, byte_rw=0, sp=01 (terminating STOP); its ok ignored, then -> DONE.
REQ-030 EVAL, byte_ok=0 on a byte with sp[0]=1: nack=1 -> DONE.
REQ-031 EVAL, success: last byte of sequence -> DONE (read: rdata<=sampled byte_rdata); else idx+1 -> ISSUE.
REQ-032 DONE: done=1 for one cycle with busy=1; next cycle busy=0, state IDLE; req accepted no earlier than that cycle.
REQ-033 rdata unchanged on write, NACK or timeout transactions.

Reset
REQ-034 rst_n=0 immediately forces state IDLE, idx=0, abort=0, counter=0, byte_valid=0, byte_wdata=0, byte_rw=0, byte_sp=00, busy=0, done=0, rdata=0, nack=0, tmo=0.
REQ-035 Reset mid-transaction issues no STOP; first post-reset byte waits for byte_right=1 per REQ-026.

Structure
REQ-036 Shared package iic_pkg holds state encoding, SP codes (SP_NONE=00, SP_STOP=01, SP_START=10), TIMEOUT default.
REQ-037 Timeout counter is sub-module iic_byte_wdog (clear, enable, expired); all else in iic_reg_seq.

Verification
REQ-038 Write dev=0x50 reg=0x10 data=0xA5, slave ACKs all -> engine sees 0xA0/sp10, 0x10/sp00, 0xA5/sp01; done, nack=0, tmo=0.
REQ-039 Read dev=0x50 reg=0x20, slave returns 0x3C -> bytes 0xA0/sp10, 0x20/sp00, 0xA1/sp10, read/sp01; done, rdata=0x3C.
REQ-040 Write dev=0x51, slave NACKs address -> 0xFF/sp01 issued next, done with nack=1, rdata unchanged.
REQ-041 Engine model holds byte_right=0 indefinitely -> done with tmo=1 after TIMEOUT cycles, busy=0 next cycle.
REQ-042 rst_n low during byte 2 of a read -> all outputs at reset values same cycle; new write after release completes normally.
REQ-043 req pulsed while busy and in done cycle -> ignored; exactly one transaction per accepted req.
